// File: rtl/spectrum_pkg.sv
// Shared constants and colour types for the spectrum bar renderer.
// Optional peak-hold display is enabled with the PEAK_HOLD_EN macro.
package spectrum_pkg;

    localparam int NBINS     = 40;
    localparam int MAG_W     = 9;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BAR_SHIFT = 4;
    localparam int MAG_MAX   = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_BAR   = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb_t COL_BG    = '{r: 4'h0, g: 4'h0, b: 4'h2};
    localparam rgb_t COL_PEAK  = '{r: 4'hF, g: 4'hF, b: 4'hF};
    localparam rgb_t COL_BLANK = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/spectrum_bin_buffer.sv
// Double-buffered bin store with write handshake and frame swap.
// With PEAK_HOLD_EN a one-cycle pulse follows every swap.
module spectrum_bin_buffer
    import spectrum_pkg::*;
#(
    parameter int NBINS = spectrum_pkg::NBINS,
    parameter int MAG_W = spectrum_pkg::MAG_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        swap_evt_i,
    input  logic                        bin_valid_i,
    output logic                        bin_ready_o,
    input  logic [5:0]                  bin_idx_i,
    input  logic [MAG_W-1:0]            bin_mag_i,
    input  logic                        bin_last_i,
    output logic                        frame_pending_o,
`ifdef PEAK_HOLD_EN
    output logic                        swapped_o,
`endif
    output logic [NBINS-1:0][MAG_W-1:0] front_o
);

    localparam logic [5:0]       NB6     = 6'(NBINS);
    localparam logic [MAG_W-1:0] MAG_CAP = MAG_W'(MAG_MAX);

    logic [1:0][NBINS-1:0][MAG_W-1:0] bank_q, bank_d;
    logic sel_q, sel_d;
    logic pend_q, pend_d;
    logic fire, swap;
    logic [MAG_W-1:0] mag_c;

    assign fire  = bin_valid_i & ~pend_q;
    assign swap  = swap_evt_i & pend_q;
    assign mag_c = (bin_mag_i > MAG_CAP) ? MAG_CAP : bin_mag_i;

    // sel_q names the bank being displayed; writes go to the other one
    always_comb begin
        bank_d = bank_q;
        sel_d  = sel_q;
        pend_d = pend_q;
        if (fire && (bin_idx_i < NB6)) begin
            bank_d[~sel_q][bin_idx_i] = mag_c;
        end
        if (fire && bin_last_i) begin
            pend_d = 1'b1;
        end
        if (swap) begin
            sel_d  = ~sel_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bank_q <= '0;
            sel_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            sel_q  <= sel_d;
            pend_q <= pend_d;
        end
    end

`ifdef PEAK_HOLD_EN
    logic swapped_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) swapped_q <= 1'b0;
        else         swapped_q <= swap;
    end

    assign swapped_o = swapped_q;
`endif

    assign front_o         = bank_q[sel_q];
    assign bin_ready_o     = ~pend_q;
    assign frame_pending_o = pend_q;

endmodule

// File: rtl/spectrum_renderer.sv
// VGA spectrum bar renderer: two-stage pixel pipeline over a swapped bin buffer.
// Define PEAK_HOLD_EN to add decaying per-bin peak markers.
module spectrum_renderer
    import spectrum_pkg::*;
#(
    parameter int NBINS = spectrum_pkg::NBINS,
    parameter int MAG_W = spectrum_pkg::MAG_W
) (
    input  logic             vgaclk,
    input  logic             rst_n,
    input  logic [9:0]       x_in,
    input  logic [9:0]       y_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic [5:0]       bin_idx,
    input  logic [MAG_W-1:0] bin_mag,
    input  logic             bin_last,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             frame_pending
);

    localparam logic [5:0] NB6 = 6'(NBINS);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);

    logic [NBINS-1:0][MAG_W-1:0] front;
    logic swap_evt;
    logic [5:0] idx;

    assign swap_evt = (x_in == 10'd0) && (y_in == VA);
    assign idx      = x_in[9:BAR_SHIFT];

`ifdef PEAK_HOLD_EN
    logic swapped;
`endif

    spectrum_bin_buffer #(
        .NBINS(NBINS),
        .MAG_W(MAG_W)
    ) u_buf (
        .clk_i          (vgaclk),
        .rst_ni         (rst_n),
        .swap_evt_i     (swap_evt),
        .bin_valid_i    (bin_valid),
        .bin_ready_o    (bin_ready),
        .bin_idx_i      (bin_idx),
        .bin_mag_i      (bin_mag),
        .bin_last_i     (bin_last),
        .frame_pending_o(frame_pending),
`ifdef PEAK_HOLD_EN
        .swapped_o      (swapped),
`endif
        .front_o        (front)
    );

    logic [9:0]       x1_q, y1_q;
    logic             hs1_q, vs1_q, hs2_q, vs2_q;
    logic [MAG_W-1:0] mag1_d, mag1_q;
    rgb_t             rgb_d, rgb_q;
    logic [9:0]       h, mag_ext;
    logic             active, bar, peak_hit;

    assign mag1_d = (idx < NB6) ? front[idx] : '0;

`ifdef PEAK_HOLD_EN
    logic [NBINS-1:0][MAG_W-1:0] peak_q, peak_d;
    logic [MAG_W-1:0] peak1_d, peak1_q;
    logic [MAG_W-1:0] dec;

    // Peaks decay by one each swap and are refreshed the cycle after it
    always_comb begin
        peak_d = peak_q;
        dec    = '0;
        if (swapped) begin
            for (int i = 0; i < NBINS; i++) begin
                dec = (peak_q[i] == '0) ? '0 : peak_q[i] - 1'b1;
                peak_d[i] = (front[i] > dec) ? front[i] : dec;
            end
        end
    end

    assign peak1_d  = (idx < NB6) ? peak_q[idx] : '0;
    assign peak_hit = (10'(peak1_q) == h) && (peak1_q != '0);

    always_ff @(posedge vgaclk) begin
        if (!rst_n) begin
            peak_q  <= '0;
            peak1_q <= '0;
        end else begin
            peak_q  <= peak_d;
            peak1_q <= peak1_d;
        end
    end
`else
    assign peak_hit = 1'b0;
`endif

    assign h       = 10'd479 - y1_q;
    assign mag_ext = 10'(mag1_q);
    assign active  = (x1_q < HA) && (y1_q < VA);
    assign bar     = mag_ext > h;

    always_comb begin
        rgb_d = COL_BLANK;
        if (active) begin
            if (peak_hit) rgb_d = COL_PEAK;
            else if (bar) rgb_d = COL_BAR;
            else          rgb_d = COL_BG;
        end
    end

    always_ff @(posedge vgaclk) begin
        if (!rst_n) begin
            x1_q   <= '0;
            y1_q   <= '0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            mag1_q <= '0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            rgb_q  <= COL_BLANK;
        end else begin
            x1_q   <= x_in;
            y1_q   <= y_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
            mag1_q <= mag1_d;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb_q  <= rgb_d;
        end
    end

    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign red       = rgb_q.r;
    assign green     = rgb_q.g;
    assign blue      = rgb_q.b;

endmodule

// File: tb/tb_spectrum_renderer.sv
// Directed bench for spectrum_renderer (honours PEAK_HOLD_EN when defined).
module tb_spectrum_renderer;

    localparam logic [11:0] BAR = 12'h0F0;
    localparam logic [11:0] BG  = 12'h002;
    localparam logic [11:0] BLK = 12'h000;
    localparam logic [11:0] WHT = 12'hFFF;

    logic       vgaclk = 1'b0;
    logic       rst_n;
    logic [9:0] x_in, y_in;
    logic       hsync_in, vsync_in;
    logic       bin_valid, bin_ready, bin_last;
    logic [5:0] bin_idx;
    logic [8:0] bin_mag;
    logic       hsync_out, vsync_out, frame_pending;
    logic [3:0] red, green, blue;

    int tests_run = 0;
    int tests_failed = 0;

    always #20 vgaclk = ~vgaclk;

    spectrum_renderer dut (
        .vgaclk       (vgaclk),
        .rst_n        (rst_n),
        .x_in         (x_in),
        .y_in         (y_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .bin_valid    (bin_valid),
        .bin_ready    (bin_ready),
        .bin_idx      (bin_idx),
        .bin_mag      (bin_mag),
        .bin_last     (bin_last),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .frame_pending(frame_pending)
    );

    task automatic tick;
        @(posedge vgaclk);
        #1;
    endtask

    task automatic idle;
        x_in      = 10'd700;
        y_in      = 10'd10;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        bin_idx   = '0;
        bin_mag   = '0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y,
                         output logic [11:0] c);
        x_in = x;
        y_in = y;
        tick;
        x_in = 10'd700;
        y_in = 10'd10;
        tick;
        c = {red, green, blue};
    endtask

    task automatic write_bin(input logic [5:0] i, input logic [8:0] m,
                             input logic l);
        bin_valid = 1'b1;
        bin_idx   = i;
        bin_mag   = m;
        bin_last  = l;
        tick;
        idle;
    endtask

    task automatic do_swap;
        x_in = 10'd0;
        y_in = 10'd480;
        tick;
        idle;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        tests_run++;
        if ({red, green, blue} !== BLK) begin
            tests_failed++;
            $display("FAIL reset_rgb got %h want %h", {red, green, blue}, BLK);
        end
        tests_run++;
        if ({hsync_out, vsync_out} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_sync got %b want 11", {hsync_out, vsync_out});
        end
        tests_run++;
        if (frame_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_pending got %b want 0", frame_pending);
        end
        rst_n = 1'b1;
        tick;
        tests_run++;
        if (bin_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready got %b want 1", bin_ready);
        end
    endtask

    task automatic test_frame;
        logic [11:0] c;
        for (int i = 0; i < 40; i++) write_bin(6'(i), 9'd100, i == 39);
        tests_run++;
        if ({frame_pending, bin_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL frame_pending got %b want 10", {frame_pending, bin_ready});
        end
        pixel(10'd5, 10'd400, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL pre_swap_pixel got %h want %h", c, BG);
        end
        bin_valid = 1'b1;
        bin_idx   = 6'd0;
        bin_mag   = 9'd300;
        tick;
        tick;
        tests_run++;
        if (bin_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL blocked_ready got %b want 0", bin_ready);
        end
        idle;
        do_swap;
        tests_run++;
        if (frame_pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_clear got %b want 0", frame_pending);
        end
        pixel(10'd5, 10'd400, c);
        tests_run++;
        if (c !== BAR) begin
            tests_failed++;
            $display("FAIL bar_5_400 got %h want %h", c, BAR);
        end
        pixel(10'd5, 10'd370, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL bg_5_370 got %h want %h", c, BG);
        end
        pixel(10'd645, 10'd400, c);
        tests_run++;
        if (c !== BLK) begin
            tests_failed++;
            $display("FAIL blank_645_400 got %h want %h", c, BLK);
        end
        pixel(10'd5, 10'd380, c);
        tests_run++;
        if (c !== BAR) begin
            tests_failed++;
            $display("FAIL edge_5_380 got %h want %h", c, BAR);
        end
        pixel(10'd5, 10'd379, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL edge_5_379 got %h want %h", c, BG);
        end
        pixel(10'd5, 10'd300, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL blocked_write got %h want %h", c, BG);
        end
    endtask

    task automatic test_discard_clamp;
        logic [11:0] c;
        write_bin(6'd45, 9'd50, 1'b0);
        write_bin(6'd2, 9'd511, 1'b0);
        write_bin(6'd1, 9'd200, 1'b1);
        do_swap;
        pixel(10'd20, 10'd300, c);
        tests_run++;
        if (c !== BAR) begin
            tests_failed++;
            $display("FAIL bin1_bar got %h want %h", c, BAR);
        end
        pixel(10'd210, 10'd479, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL discard_alias got %h want %h", c, BG);
        end
        pixel(10'd5, 10'd479, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL retained_bin0 got %h want %h", c, BG);
        end
        tests_run++;
        if (dut.u_buf.front_o[2] !== 9'd480) begin
            tests_failed++;
            $display("FAIL clamp got %0d want 480", dut.u_buf.front_o[2]);
        end
    endtask

    task automatic test_last_at_swap;
        logic [11:0] c;
        write_bin(6'd0, 9'd50, 1'b0);
        x_in      = 10'd0;
        y_in      = 10'd480;
        bin_valid = 1'b1;
        bin_idx   = 6'd5;
        bin_mag   = 9'd300;
        bin_last  = 1'b1;
        tick;
        idle;
        tests_run++;
        if (frame_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL last_at_swap_pend got %b want 1", frame_pending);
        end
        pixel(10'd90, 10'd300, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL no_early_swap got %h want %h", c, BG);
        end
        do_swap;
        pixel(10'd90, 10'd300, c);
        tests_run++;
        if (c !== BAR) begin
            tests_failed++;
            $display("FAIL late_swap got %h want %h", c, BAR);
        end
        pixel(10'd5, 10'd400, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL bin0_50 got %h want %h", c, BG);
        end
    endtask

    task automatic test_peak;
        logic [11:0] c;
        logic [11:0] exp_w;
        for (int i = 0; i < 40; i++) write_bin(6'(i), 9'd200, i == 39);
        do_swap;
`ifdef PEAK_HOLD_EN
        exp_w = WHT;
`else
        exp_w = BG;
`endif
        pixel(10'd50, 10'd280, c);
        tests_run++;
        if (c !== BAR) begin
            tests_failed++;
            $display("FAIL peak_frame1_bar got %h want %h", c, BAR);
        end
        pixel(10'd50, 10'd279, c);
        tests_run++;
        if (c !== exp_w) begin
            tests_failed++;
            $display("FAIL peak_200 got %h want %h", c, exp_w);
        end
        write_bin(6'd3, 9'd0, 1'b1);
        do_swap;
        pixel(10'd50, 10'd280, c);
        tests_run++;
        if (c !== exp_w) begin
            tests_failed++;
            $display("FAIL peak_199 got %h want %h", c, exp_w);
        end
        pixel(10'd50, 10'd279, c);
        tests_run++;
        if (c !== BG) begin
            tests_failed++;
            $display("FAIL peak_above got %h want %h", c, BG);
        end
    endtask

    task automatic test_sync;
        x_in     = 10'd5;
        y_in     = 10'd440;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        tick;
        tests_run++;
        if ({hsync_out, vsync_out} !== 2'b11) begin
            tests_failed++;
            $display("FAIL sync_n1 got %b want 11", {hsync_out, vsync_out});
        end
        x_in     = 10'd645;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        tick;
        tests_run++;
        if ({hsync_out, vsync_out, red, green, blue} !== {2'b00, BAR}) begin
            tests_failed++;
            $display("FAIL sync_n2 got %b/%h want 00/%h",
                     {hsync_out, vsync_out}, {red, green, blue}, BAR);
        end
        idle;
        tick;
        tests_run++;
        if ({hsync_out, vsync_out, red, green, blue} !== {2'b11, BLK}) begin
            tests_failed++;
            $display("FAIL sync_n3 got %b/%h want 11/%h",
                     {hsync_out, vsync_out}, {red, green, blue}, BLK);
        end
    endtask

    initial begin
        idle;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        test_reset;
        test_frame;
        test_discard_clamp;
        test_last_at_swap;
        test_peak;
        test_sync;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
